// File: rtl/ws2812_in_pkg.sv
// ---------------------------------------------------------------------------
// Module   : ws2812_in_pkg
// Brief    : Shared timing defaults, widths and state encodings for ws2812_in.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

package ws2812_in_pkg;

    // Pulse timing defaults for a 50 MHz clk_in.
    localparam int c_T_MIN_HIGH = 5;
    localparam int c_T_THRESH   = 30;
    localparam int c_T_MAX_HIGH = 60;
    localparam int c_T_RESET    = 2500;
    localparam int c_PIX_NUM    = 64;

    localparam int c_PIX_W = 24;
    localparam int c_IDX_W = 6;
    localparam int c_CNT_W = 12;

    typedef enum logic [1:0] {
        ST_RESYNC = 2'd0,
        ST_IDLE   = 2'd1,
        ST_HIGH   = 2'd2,
        ST_LOW    = 2'd3
    } state_t;

    function automatic logic [c_CNT_W-1:0] sat_inc(input logic [c_CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ws2812_in_if.sv
// ---------------------------------------------------------------------------
// Module   : ws2812_in_if
// Brief    : Decoded pixel / frame status bundle produced by ws2812_in.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

interface ws2812_in_if;
    import ws2812_in_pkg::*;

    logic                 pixel_valid_out;
    logic [c_PIX_W-1:0]   pixel_data_out;
    logic [c_IDX_W-1:0]   pixel_idx_out;
    logic                 frame_done_out;
    logic                 err_out;

    modport master (
        output pixel_valid_out,
        output pixel_data_out,
        output pixel_idx_out,
        output frame_done_out,
        output err_out
    );

    modport slave (
        input  pixel_valid_out,
        input  pixel_data_out,
        input  pixel_idx_out,
        input  frame_done_out,
        input  err_out
    );

endinterface

`default_nettype wire

// File: rtl/ws2812_in_pulse_meas.sv
// ---------------------------------------------------------------------------
// Module   : ws2812_pulse_meas
// Brief    : Synchronises the WS2812 line, measures high/low widths and
//            classifies each pulse into bit / gap / error events.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module ws2812_pulse_meas
    import ws2812_in_pkg::*;
#(
    parameter int T_MIN_HIGH = c_T_MIN_HIGH,
    parameter int T_THRESH   = c_T_THRESH,
    parameter int T_MAX_HIGH = c_T_MAX_HIGH,
    parameter int T_RESET    = c_T_RESET
) (
    input  wire logic clk_in,
    input  wire logic rst_in,
    input  wire logic i_line,
    output logic      o_bit_rdy,
    output logic      o_bit_data,
    output logic      o_gap_done,
    output logic      o_pulse_err
);

    localparam logic [c_CNT_W-1:0] c_MIN_CNT   = c_CNT_W'(T_MIN_HIGH);
    localparam logic [c_CNT_W-1:0] c_THR_CNT   = c_CNT_W'(T_THRESH);
    localparam logic [c_CNT_W-1:0] c_MAX_CNT   = c_CNT_W'(T_MAX_HIGH);
    localparam logic [c_CNT_W-1:0] c_RESET_CNT = c_CNT_W'(T_RESET);

    logic               r_sync1;
    logic               r_sync2;
    logic               r_dly;
    logic               w_rise;
    logic               w_fall;

    state_t             r_state;
    state_t             w_state_nxt;
    state_t             r_prev_low;
    state_t             w_prev_low_nxt;
    logic [c_CNT_W-1:0] r_high_cnt;
    logic [c_CNT_W-1:0] w_high_cnt_nxt;
    logic [c_CNT_W-1:0] r_low_cnt;
    logic [c_CNT_W-1:0] w_low_cnt_nxt;

    logic               w_bit_rdy;
    logic               w_bit_data;
    logic               w_gap_done;
    logic               w_pulse_err;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_dly   <= 1'b0;
        end else begin
            r_sync1 <= i_line;
            r_sync2 <= r_sync1;
            r_dly   <= r_sync2;
        end
    end

    assign w_rise = r_sync2 & ~r_dly;
    assign w_fall = ~r_sync2 & r_dly;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state     <= ST_RESYNC;
            r_prev_low  <= ST_IDLE;
            r_high_cnt  <= '0;
            r_low_cnt   <= '0;
            o_bit_rdy   <= 1'b0;
            o_bit_data  <= 1'b0;
            o_gap_done  <= 1'b0;
            o_pulse_err <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_prev_low  <= w_prev_low_nxt;
            r_high_cnt  <= w_high_cnt_nxt;
            r_low_cnt   <= w_low_cnt_nxt;
            o_bit_rdy   <= w_bit_rdy;
            o_bit_data  <= w_bit_data;
            o_gap_done  <= w_gap_done;
            o_pulse_err <= w_pulse_err;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_prev_low_nxt = r_prev_low;
        w_high_cnt_nxt = r_high_cnt;
        w_low_cnt_nxt  = r_low_cnt;
        w_bit_rdy      = 1'b0;
        w_bit_data     = 1'b0;
        w_gap_done     = 1'b0;
        w_pulse_err    = 1'b0;

        case (r_state)
            ST_RESYNC: begin
                if (r_sync2) begin
                    w_low_cnt_nxt = '0;
                end else if (r_low_cnt >= c_RESET_CNT) begin
                    w_state_nxt   = ST_IDLE;
                    w_low_cnt_nxt = '0;
                end else begin
                    w_low_cnt_nxt = sat_inc(r_low_cnt);
                end
            end

            ST_IDLE: begin
                if (w_rise) begin
                    w_state_nxt    = ST_HIGH;
                    w_high_cnt_nxt = c_CNT_W'(1);
                    w_prev_low_nxt = ST_IDLE;
                end
            end

            ST_HIGH: begin
                if (r_high_cnt > c_MAX_CNT) begin
                    w_state_nxt   = ST_RESYNC;
                    w_low_cnt_nxt = '0;
                    w_pulse_err   = 1'b1;
                end else if (w_fall) begin
                    // A glitch resumes the interrupted low phase; low_cnt was held meanwhile.
                    if (r_high_cnt < c_MIN_CNT) begin
                        w_state_nxt = r_prev_low;
                    end else begin
                        w_bit_rdy     = 1'b1;
                        w_bit_data    = (r_high_cnt >= c_THR_CNT);
                        w_state_nxt   = ST_LOW;
                        w_low_cnt_nxt = c_CNT_W'(1);
                    end
                end else begin
                    w_high_cnt_nxt = sat_inc(r_high_cnt);
                end
            end

            ST_LOW: begin
                if (r_low_cnt >= c_RESET_CNT) begin
                    // Frame end wins; a coincident rise opens the next frame at once.
                    w_gap_done     = 1'b1;
                    w_low_cnt_nxt  = '0;
                    w_prev_low_nxt = ST_IDLE;
                    if (w_rise) begin
                        w_state_nxt    = ST_HIGH;
                        w_high_cnt_nxt = c_CNT_W'(1);
                    end else begin
                        w_state_nxt    = ST_IDLE;
                    end
                end else if (w_rise) begin
                    w_state_nxt    = ST_HIGH;
                    w_high_cnt_nxt = c_CNT_W'(1);
                    w_prev_low_nxt = ST_LOW;
                end else begin
                    w_low_cnt_nxt = sat_inc(r_low_cnt);
                end
            end

            default: begin
                w_state_nxt = ST_RESYNC;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/ws2812_in.sv
// ---------------------------------------------------------------------------
// Module   : ws2812_in
// Brief    : WS2812 line receiver; assembles 24-bit GRB words MSB-first and
//            emits indexed pixels plus frame-done / sticky error status.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module ws2812_in
    import ws2812_in_pkg::*;
#(
    parameter int T_MIN_HIGH = c_T_MIN_HIGH,
    parameter int T_THRESH   = c_T_THRESH,
    parameter int T_MAX_HIGH = c_T_MAX_HIGH,
    parameter int T_RESET    = c_T_RESET,
    parameter int PIX_NUM    = c_PIX_NUM
) (
    input  wire logic      clk_in,
    input  wire logic      rst_in,
    input  wire logic      ws2812_data_in,
    ws2812_in_if.master    o_pix
);

    localparam logic [c_IDX_W:0] c_PIX_LIMIT = (c_IDX_W + 1)'(PIX_NUM);
    localparam logic [4:0]       c_LAST_BIT  = 5'(c_PIX_W - 1);

    logic                 w_bit_rdy;
    logic                 w_bit_data;
    logic                 w_gap_done;
    logic                 w_pulse_err;
    logic [c_PIX_W-1:0]   w_word;

    logic [c_PIX_W-2:0]   r_shift;
    logic [4:0]           r_bit_cnt;
    logic [c_IDX_W:0]     r_pix_cnt;
    logic                 r_frame_err;
    logic                 r_valid;
    logic [c_PIX_W-1:0]   r_data;
    logic [c_IDX_W-1:0]   r_idx;
    logic                 r_frame_done;
    logic                 r_err;

    ws2812_pulse_meas #(
        .T_MIN_HIGH (T_MIN_HIGH),
        .T_THRESH   (T_THRESH),
        .T_MAX_HIGH (T_MAX_HIGH),
        .T_RESET    (T_RESET)
    ) u_pulse_meas (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .i_line      (ws2812_data_in),
        .o_bit_rdy   (w_bit_rdy),
        .o_bit_data  (w_bit_data),
        .o_gap_done  (w_gap_done),
        .o_pulse_err (w_pulse_err)
    );

    assign w_word = {r_shift, w_bit_data};

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_shift      <= '0;
            r_bit_cnt    <= '0;
            r_pix_cnt    <= '0;
            r_frame_err  <= 1'b0;
            r_valid      <= 1'b0;
            r_data       <= '0;
            r_idx        <= '0;
            r_frame_done <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_valid      <= 1'b0;
            r_frame_done <= 1'b0;

            if (w_pulse_err) begin
                // Over-long pulse: drop the partial word and restart framing after resync.
                r_bit_cnt   <= '0;
                r_pix_cnt   <= '0;
                r_frame_err <= 1'b0;
                r_err       <= 1'b1;
            end else if (w_gap_done) begin
                r_frame_done <= 1'b1;
                r_bit_cnt    <= '0;
                r_pix_cnt    <= '0;
                r_frame_err  <= 1'b0;
                r_err        <= r_frame_err | (r_bit_cnt != 5'd0);
            end else if (w_bit_rdy) begin
                r_shift <= w_word[c_PIX_W-2:0];
                if (r_bit_cnt == c_LAST_BIT) begin
                    r_bit_cnt <= '0;
                    if (r_pix_cnt < c_PIX_LIMIT) begin
                        r_valid   <= 1'b1;
                        r_data    <= w_word;
                        r_idx     <= r_pix_cnt[c_IDX_W-1:0];
                        r_pix_cnt <= r_pix_cnt + 1'b1;
                    end else begin
                        r_frame_err <= 1'b1;
                        r_err       <= 1'b1;
                    end
                end else begin
                    r_bit_cnt <= r_bit_cnt + 1'b1;
                end
            end
        end
    end

    assign o_pix.pixel_valid_out = r_valid;
    assign o_pix.pixel_data_out  = r_data;
    assign o_pix.pixel_idx_out   = r_idx;
    assign o_pix.frame_done_out  = r_frame_done;
    assign o_pix.err_out         = r_err;

endmodule

`default_nettype wire

// File: doc/ws2812_in.md
Name: ws2812_in

Overview:
- WS2812 line receiver: the inverse of the pixel output path.
- Samples a single-wire WS2812 data stream, classifies each high pulse as a 0 or 1 bit by its width, and assembles 24-bit GRB words MSB-first.
- Emits one indexed pixel per word, ready to write into a 64-entry layer RAM.
- Used for chain loopback checking and for a chained-controller input port.

Parameters:
- T_MIN_HIGH, 5, high pulses shorter than this many clk_in cycles are glitches and are ignored.
- T_THRESH, 30, high width >= T_THRESH cycles decodes as 1, otherwise as 0 (50 MHz: T0H=20, T1H=40).
- T_MAX_HIGH, 60, high width > T_MAX_HIGH cycles is a protocol error.
- T_RESET, 2500, low width >= T_RESET cycles ends the frame (50 us at 50 MHz).
- PIX_NUM, 64, pixels accepted per frame; must be <= 64.

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  asynchronous, active-high reset.
- ws2812_data_in  input  1  asynchronous WS2812 line.
- pixel_valid_out  output  1  one-cycle strobe: pixel_data_out and pixel_idx_out are valid.
- pixel_data_out  output  24  decoded GRB word; first received bit is in bit 23.
- pixel_idx_out  output  6  pixel index within the frame, 0..PIX_NUM-1.
- frame_done_out  output  1  one-cycle strobe when a reset gap ends a frame.
- err_out  output  1  sticky error flag; cleared by reset or by the next frame_done_out.

Behaviour:
- Clock and reset: one clock, clk_in. Reset rst_in is asynchronous and active-high.
- Reset values: all outputs 0, state RESYNC, all counters 0, synchroniser flops 0.
- Input conditioning: 2-flop synchroniser, then a registered delayed copy for rise/fall edge detection.
- Width counters: 12-bit high_cnt and low_cnt, saturating at all-ones, never wrapping.
- State RESYNC:
  - Counts low time; any high level clears low_cnt.
  - low_cnt reaching T_RESET -> IDLE.
  - No frame_done_out is issued from RESYNC.
- State IDLE: rising edge -> HIGH with high_cnt=1.
- State HIGH: high_cnt increments each cycle.
  - high_cnt > T_MAX_HIGH -> set err_out, discard the partial word, go to RESYNC.
  - Falling edge with high_cnt < T_MIN_HIGH -> back to the previous low phase; no bit, and low_cnt continues from its previous value.
  - Falling edge otherwise -> shift in bit (high_cnt >= T_THRESH), bit_cnt++, go to LOW with low_cnt=1.
- State LOW: low_cnt increments each cycle.
  - Rising edge -> HIGH.
  - low_cnt reaching T_RESET -> frame end, then IDLE.
- Pixel emission:
  - When bit_cnt reaches 24: pixel_valid_out pulses for 1 cycle, pixel_data_out holds the word, pixel_idx_out holds pix_cnt, then pix_cnt++ and bit_cnt=0.
  - Latency: pin falling edge of bit 24 -> pixel_valid_out high exactly 4 clk_in cycles later (2 sync + 1 edge + 1 output register).
  - pixel_data_out and pixel_idx_out hold their values between strobes.
- Overflow: once pix_cnt == PIX_NUM, further words are decoded but not emitted; err_out is set once; pix_cnt holds.
- Frame end:
  - frame_done_out pulses 1 cycle.
  - pix_cnt=0 and bit_cnt=0.
  - bit_cnt != 0 at frame end (partial word) -> err_out set, word discarded.
  - err_out is cleared on the frame_done_out of a frame that is itself error-free.
  - Two consecutive reset gaps with no bits between them produce no second frame_done_out.
- Simultaneous events:
  - A rising edge on the same cycle low_cnt reaches T_RESET: the frame end wins, and the rise starts a new frame from IDLE in that same cycle.
  - A pixel strobe and a frame-end strobe are never in the same cycle, because they are separated by at least T_RESET cycles.
- Reset mid-operation: immediate return to RESYNC. The partial word is lost and no strobes are produced. After reset release the block needs a full T_RESET low gap before it decodes again.

Decomposition:
- Shared package: T_* timing defaults for the 50 MHz clock; PIX_NUM; 24-bit pixel width; state encodings RESYNC/IDLE/HIGH/LOW.
- One natural sub-module: ws2812_pulse_meas. It holds the synchroniser, edge detector and width counters, and outputs bit_rdy, bit_data, gap_done and pulse_err to the framing FSM.

Test Plan:
- Reset, 2500-cycle low gap, then 24 bits encoding 0xA5C3F0 (T0H=20/T0L=42, T1H=40/T1L=22), then a 2500-cycle low gap:
  - one pixel_valid_out with data 0xA5C3F0 and idx 0, 4 cycles after the last fall;
  - frame_done_out once;
  - err_out=0.
- 65 pixels 0x000001..0x000041 in one frame:
  - 64 strobes with idx 0..63;
  - the 65th pixel is not emitted;
  - err_out=1 at frame end.
- 3-cycle high glitch inserted between bits of 0xFFFFFF: decoded word is still 0xFFFFFF; no error.
- 70-cycle high pulse: err_out=1, no pixel. A following 2500-cycle gap plus a valid pixel 0x123456 is then received correctly with idx 0.
- 12 bits followed by a reset gap: frame_done_out pulses, no pixel_valid_out, err_out=1. The next clean frame clears err_out.
- rst_in asserted after the 10th bit of a pixel: all outputs 0 immediately. After release, bits sent without a leading 2500-cycle gap are ignored.
